bl_hash_ctrl: RTL



---
 rtl/bl_hash_pkg.sv | 18 +
 rtl/bl_hash_iter.sv | 55 +++++
 rtl/bl_hash_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bl_hash_pkg.sv
// Shared types and hash constants for the blacklist hash controller.
package bl_hash_pkg;

  localparam int unsigned HASH_SEED = 31;
  localparam int unsigned HASH_MUL  = 17;

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    COMMIT
  } state_t;

  typedef enum logic {
    REQ_INS,
    REQ_CHK
  } req_t;

endpackage

// File: rtl/bl_hash_iter.sv
// Iterative hash engine: one HASH_SIZE chunk per cycle, least significant chunk first.
module bl_hash_iter
  import bl_hash_pkg::*;
#(
  parameter int unsigned D_SIZE    = 32,
  parameter int unsigned HASH_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [D_SIZE-1:0]    data_i,
  output logic                 done_o,
  output logic [HASH_SIZE-1:0] hash_o
);

  localparam int unsigned N  = D_SIZE / HASH_SIZE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [D_SIZE-1:0]    data_q;
  logic [HASH_SIZE-1:0] hash_q;
  logic [HASH_SIZE-1:0] step;
  logic [CW-1:0]        cnt_q;
  logic                 run_q;

  // Product is taken at HASH_SIZE width, so the modulo is implicit.
  always_comb begin
    step = (hash_q ^ data_q[HASH_SIZE-1:0]) * HASH_SIZE'(HASH_MUL);
  end

  // done_o flags the cycle consuming the final chunk; hash_o is final one cycle later.
  assign done_o = run_q && (cnt_q == CW'(N - 1));
  assign hash_o = hash_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      hash_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      data_q <= data_i;
      hash_q <= HASH_SIZE'(HASH_SEED);
      cnt_q  <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      hash_q <= step;
      data_q <= data_q >> HASH_SIZE;
      cnt_q  <= cnt_q + 1'b1;
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bl_hash_ctrl.sv
// Arbitrates insert/check requests onto one iterative hash engine and
// maintains a FIFO-replaced blacklist table of hashes.
module bl_hash_ctrl
  import bl_hash_pkg::*;
#(
  parameter int unsigned D_SIZE      = 32,
  parameter int unsigned HASH_SIZE   = 16,
  parameter int unsigned TABLE_DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           ins_req_i,
  input  logic [D_SIZE-1:0]              ins_data_i,
  output logic                           ins_gnt_o,
  input  logic                           chk_req_i,
  input  logic [D_SIZE-1:0]              chk_data_i,
  output logic                           chk_gnt_o,
  input  logic                           clear_i,
  output logic                           rsp_valid_o,
  output logic                           rsp_is_chk_o,
  output logic                           rsp_hit_o,
  output logic [HASH_SIZE-1:0]           rsp_hash_o,
  output logic                           busy_o,
  output logic                           full_o,
  output logic [$clog2(TABLE_DEPTH):0]   count_o
);

  localparam int unsigned AW   = $clog2(TABLE_DEPTH);
  localparam int unsigned CNTW = AW + 1;

  state_t state_q, state_d;
  req_t   type_q, last_q;

  logic                 ins_gnt, chk_gnt, start;
  logic [D_SIZE-1:0]    start_data;
  logic                 eng_done;
  logic [HASH_SIZE-1:0] eng_hash;

  logic [TABLE_DEPTH-1:0] valid_q;
  logic [HASH_SIZE-1:0]   entry_q [TABLE_DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [CNTW-1:0]        count_q;
  logic                   full;

  logic                 commit, match, do_write;
  logic [HASH_SIZE-1:0] rsp_hash_q;
  logic                 rsp_hit_q, rsp_is_chk_q;

  always_comb begin
    state_d = state_q;
    ins_gnt = 1'b0;
    chk_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        // Contention goes to the type not granted last.
        if (ins_req_i && chk_req_i) begin
          if (last_q == REQ_CHK) ins_gnt = 1'b1;
          else                   chk_gnt = 1'b1;
        end else begin
          ins_gnt = ins_req_i;
          chk_gnt = chk_req_i;
        end
        if (ins_gnt || chk_gnt) state_d = HASH;
      end
      HASH:    if (eng_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start      = ins_gnt | chk_gnt;
  assign start_data = chk_gnt ? chk_data_i : ins_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      type_q  <= REQ_INS;
      last_q  <= REQ_INS;
    end else begin
      state_q <= state_d;
      if (start) begin
        type_q <= chk_gnt ? REQ_CHK : REQ_INS;
        last_q <= chk_gnt ? REQ_CHK : REQ_INS;
      end
    end
  end

  bl_hash_iter #(
    .D_SIZE   (D_SIZE),
    .HASH_SIZE(HASH_SIZE)
  ) u_iter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start),
    .data_i (start_data),
    .done_o (eng_done),
    .hash_o (eng_hash)
  );

  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i] == eng_hash)) match = 1'b1;
    end
  end

  assign commit   = (state_q == COMMIT);
  // A clear in the commit cycle wins: the response still sees the old table.
  assign do_write = commit && (type_q == REQ_INS) && !match && !clear_i;
  assign full     = (count_q == CNTW'(TABLE_DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (do_write) begin
      valid_q[wr_ptr_q] <= 1'b1;
      wr_ptr_q          <= wr_ptr_q + 1'b1;
      if (!full) count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) entry_q[wr_ptr_q] <= eng_hash;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_hash_q   <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_is_chk_q <= 1'b0;
    end else if (commit) begin
      rsp_hash_q   <= eng_hash;
      rsp_hit_q    <= match;
      rsp_is_chk_q <= (type_q == REQ_CHK);
    end
  end

  assign ins_gnt_o    = ins_gnt;
  assign chk_gnt_o    = chk_gnt;
  assign rsp_valid_o  = commit;
  assign rsp_hash_o   = commit ? eng_hash : rsp_hash_q;
  assign rsp_hit_o    = commit ? match : rsp_hit_q;
  assign rsp_is_chk_o = commit ? (type_q == REQ_CHK) : rsp_is_chk_q;
  assign busy_o       = (state_q != IDLE);
  assign full_o       = full;
  assign count_o      = count_q;

endmodule
